// File: rtl/arb_xfer_ctrl.sv
// arb_xfer_ctrl: consumes a registered one-hot arbiter grant and runs a
// fixed-length valid/ready burst for the granted requester. A DONE cycle and
// a GAP cycle after each burst keep the arbiter's lagging grant from starting
// a second, unwanted burst for the requester that just finished.
module arb_xfer_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BEAT_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            gnt,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [DATA_W-1:0]     bus_data,
  output logic [1:0]            bus_src,
  output logic                  bus_last,
  output logic [3:0]            done,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CntW = (BEAT_CNT > 1) ? $clog2(BEAT_CNT) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(BEAT_CNT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone,
    StGap
  } state_e;

  state_e          state;
  logic [CntW-1:0] beat_cnt;

  logic            gnt_onehot;
  logic            gnt_multi;
  logic [1:0]      gnt_idx;
  logic            accept;
  logic [CntW-1:0] beat_nxt;

  // Classify the incoming grant and encode its index
  always_comb begin
    gnt_onehot = (gnt != 4'b0000) && ((gnt & (gnt - 4'd1)) == 4'b0000);
    gnt_multi  = (gnt != 4'b0000) && !gnt_onehot;
    gnt_idx    = 2'd0;
    case (gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  // Beat handshake and next beat index
  always_comb begin
    accept   = bus_valid && bus_ready;
    beat_nxt = beat_cnt + CntW'(1);
  end

  // Burst control FSM; all outputs except bus_data are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      beat_cnt  <= '0;
      bus_valid <= 1'b0;
      bus_last  <= 1'b0;
      bus_src   <= 2'd0;
      busy      <= 1'b0;
      done      <= 4'b0000;
      err       <= 1'b0;
    end else begin
      // err and done are single-cycle pulses
      err  <= 1'b0;
      done <= 4'b0000;
      case (state)
        StIdle: begin
          busy      <= 1'b0;
          bus_valid <= 1'b0;
          bus_last  <= 1'b0;
          if (gnt_onehot) begin
            bus_src   <= gnt_idx;
            beat_cnt  <= '0;
            busy      <= 1'b1;
            bus_valid <= 1'b1;
            bus_last  <= (LastIdx == '0);
            state     <= StXfer;
          end else if (gnt_multi) begin
            err <= 1'b1;
          end
        end
        StXfer: begin
          // gnt is deliberately not looked at while a burst is in flight
          if (accept) begin
            if (beat_cnt == LastIdx) begin
              bus_valid     <= 1'b0;
              bus_last      <= 1'b0;
              done[bus_src] <= 1'b1;
              state         <= StDone;
            end else begin
              beat_cnt <= beat_nxt;
              bus_last <= (beat_nxt == LastIdx);
            end
          end
        end
        StDone: begin
          state <= StGap;
        end
        StGap: begin
          // Guard cycle: the arbiter's stale grant is still visible here
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Drive the bus with the latched source's data word
  always_comb begin
    bus_data = req_data[DATA_W-1:0];
    case (bus_src)
      2'd1:    bus_data = req_data[1*DATA_W +: DATA_W];
      2'd2:    bus_data = req_data[2*DATA_W +: DATA_W];
      2'd3:    bus_data = req_data[3*DATA_W +: DATA_W];
      default: bus_data = req_data[0 +: DATA_W];
    endcase
  end

endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// Bench for arb_xfer_ctrl: directed grant/ready sequences, a transaction-level
// model compared every cycle, and hand-computed expectations per scenario.
module tb_arb_xfer_ctrl;
  localparam int DW = 8;
  localparam int BC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    gnt = 4'b0000;
  logic [4*DW-1:0] req_data;
  logic          bus_ready = 1'b0;
  logic          bus_valid;
  logic [DW-1:0] bus_data;
  logic [1:0]    bus_src;
  logic          bus_last;
  logic [3:0]    done;
  logic          busy;
  logic          err;

  arb_xfer_ctrl #(.DATA_W(DW), .BEAT_CNT(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .gnt       (gnt),
    .req_data  (req_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .bus_src   (bus_src),
    .bus_last  (bus_last),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [3:0] done_seen = 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: beats remaining in the burst, and cycles of
  // post-burst quiet time (done pulse, then guard) before grants count again.
  logic       m_valid = 1'b0, m_last = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  logic [1:0] m_src = 2'd0;
  logic [3:0] m_done = 4'b0000;
  int         m_left = 0;
  int         m_tail = 0;
  logic [1:0] g_idx;

  always_comb begin
    g_idx = 2'd0;
    for (int i = 0; i < 4; i++) if (gnt[i]) g_idx = 2'(i);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0; m_last <= 0; m_busy <= 0; m_err <= 0;
      m_src <= 0; m_done <= 0; m_left <= 0; m_tail <= 0;
    end else begin
      m_err  <= 0;
      m_done <= 0;
      if (m_left > 0) begin
        if (bus_ready) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_valid <= 0;
            m_last  <= 0;
            m_done  <= 4'b0001 << m_src;
            m_tail  <= 2;
          end else begin
            m_last <= (m_left == 2);
          end
        end
      end else if (m_tail > 0) begin
        m_tail <= m_tail - 1;
        if (m_tail == 1) m_busy <= 0;
      end else if ($countones(gnt) > 1) begin
        m_err <= 1;
      end else if ($countones(gnt) == 1) begin
        m_src   <= g_idx;
        m_left  <= BC;
        m_valid <= 1;
        m_busy  <= 1;
        m_last  <= (BC == 1);
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  logic [DW-1:0] exp_data;
  always @(negedge clk) begin
    check("bus_valid", bus_valid, m_valid);
    check("bus_last", bus_last, m_last);
    check("bus_src", bus_src, m_src);
    check("done", done, m_done);
    check("busy", busy, m_busy);
    check("err", err, m_err);
    if (m_valid) begin
      exp_data = req_data[int'(m_src)*DW +: DW];
      check("bus_data", bus_data, exp_data);
    end
    if (bus_valid && bus_ready) acc_cnt++;
    done_seen = done_seen | done;
  end

  task automatic step(input logic [3:0] g, input logic r);
    gnt = g;
    bus_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(4'b0000, 1'b1);
      n++;
    end
    check("drain_busy_low", busy, 0);
  endtask

  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    req_data = {8'h5C, 8'h33, 8'h96, 8'hA5};
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_valid", bus_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_src", bus_src, 0);
    step(4'b0000, 1'b0);

    // Single burst from requester 0
    acc_cnt = 0;
    step(4'b0001, 1'b1);
    check("t1_valid", bus_valid, 1);
    check("t1_data", bus_data, 8'hA5);
    check("t1_last0", bus_last, 0);
    repeat (3) step(4'b0000, 1'b1);
    check("t1_last", bus_last, 1);
    step(4'b0000, 1'b1);
    check("t1_done", done, 4'b0001);
    check("t1_valid_off", bus_valid, 0);
    step(4'b0000, 1'b0);
    check("t1_done_off", done, 0);
    check("t1_gap_busy", busy, 1);
    step(4'b0000, 1'b0);
    check("t1_idle_busy", busy, 0);
    check("t1_beats", acc_cnt, 4);

    // Backpressure on requester 2
    acc_cnt = 0;
    step(4'b0100, 1'b0);
    check("t2_src", bus_src, 2);
    for (int i = 0; i < 6; i++) step(4'b0000, pat[i][0]);
    check("t2_stall_valid", bus_valid, 1);
    check("t2_stall_last", bus_last, 1);
    check("t2_no_early_done", done, 0);
    step(4'b0000, pat[6][0]);
    check("t2_done", done, 4'b0100);
    drain(10);
    check("t2_beats", acc_cnt, 4);

    // Grant changes mid-burst
    acc_cnt = 0;
    step(4'b1000, 1'b1);
    check("t3_src", bus_src, 3);
    check("t3_data", bus_data, 8'h5C);
    step(4'b1000, 1'b1);
    repeat (3) step(4'b0001, 1'b1);
    check("t3_done", done, 4'b1000);
    step(4'b0001, 1'b1);
    check("t3_gap_valid", bus_valid, 0);
    check("t3_gap_busy", busy, 1);
    step(4'b0001, 1'b1);
    check("t3_idle_busy", busy, 0);
    step(4'b0001, 1'b1);
    check("t3_next_valid", bus_valid, 1);
    check("t3_next_src", bus_src, 0);
    drain(10);
    check("t3_beats", acc_cnt, 8);

    // Stale grant held past done
    acc_cnt = 0;
    step(4'b0010, 1'b1);
    repeat (4) step(4'b0010, 1'b1);
    check("t4_done", done, 4'b0010);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("t4_no_restart", bus_valid, 0);
    check("t4_idle_busy", busy, 0);
    check("t4_beats", acc_cnt, 4);
    step(4'b0010, 1'b1);
    check("t4_fresh_valid", bus_valid, 1);
    check("t4_fresh_data", bus_data, 8'h96);
    drain(10);

    // Illegal grant in IDLE
    step(4'b0011, 1'b1);
    check("t5_err", err, 1);
    check("t5_valid", bus_valid, 0);
    step(4'b0010, 1'b1);
    check("t5_err_off", err, 0);
    check("t5_valid_on", bus_valid, 1);
    check("t5_src", bus_src, 1);
    drain(10);

    // Reset mid-burst
    done_seen = 4'b0000;
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_valid", bus_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check("t6_no_done", done_seen, 0);
    acc_cnt = 0;
    step(4'b0001, 1'b1);
    check("t6_restart", bus_valid, 1);
    drain(10);
    check("t6_beats", acc_cnt, 4);
    check("t6_done_seen", done_seen, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
